// File: rtl/output_argmax.sv
// Streaming argmax over NUM_CLASSES signed scores, with a result handshake.
// Optional: define OUTPUT_ARGMAX_MARGIN_EN to add the max-minus-second-max margin output.
module output_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  output logic               score_ready,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [3:0]         class_idx,
  output logic [SCORE_W-1:0] max_score
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W:0]   margin
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RESULT} state_t;

  localparam logic [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [3:0]         LAST     = 4'(NUM_CLASSES - 1);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, r_run_idx, r_class_idx;
  logic [SCORE_W-1:0] r_run_max, r_max_score;
  logic               w_xfer, w_last, w_take, w_restart;
  logic [SCORE_W-1:0] w_max_nxt;
  logic [3:0]         w_idx_nxt;

  // A beat arriving with start in COLLECT is dropped: the restart wins.
  assign w_xfer    = (r_state == S_COLLECT) && score_valid && !start;
  assign w_last    = w_xfer && (r_cnt == LAST);
  assign w_restart = start && (r_state != S_RESULT);
  // Beat 0 always loads; afterwards only a strictly greater score wins, so ties keep the lower index.
  assign w_take    = (r_cnt == 4'd0) || ($signed(score) > $signed(r_run_max));
  assign w_max_nxt = w_take ? score : r_run_max;
  assign w_idx_nxt = w_take ? r_cnt : r_run_idx;

  assign class_idx = r_class_idx;
  assign max_score = r_max_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    score_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        score_ready = 1'b1;
        busy        = 1'b1;
        if (w_last) w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Running max lives apart from the published result so outputs hold through IDLE and COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_run_idx   <= '0;
      r_run_max   <= '0;
      r_class_idx <= '0;
      r_max_score <= '0;
    end else if (w_restart) begin
      r_cnt     <= '0;
      r_run_idx <= '0;
      r_run_max <= MOST_NEG;
    end else if (w_xfer) begin
      r_cnt     <= w_last ? 4'd0 : r_cnt + 4'd1;
      r_run_idx <= w_idx_nxt;
      r_run_max <= w_max_nxt;
      if (w_last) begin
        r_class_idx <= w_idx_nxt;
        r_max_score <= w_max_nxt;
      end
    end
  end

`ifdef OUTPUT_ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0] r_second, w_sec_nxt;
  logic [SCORE_W:0]   r_margin, w_margin_nxt;

  // A tie with the max also passes the "greater than second" test, which makes the margin 0.
  assign w_sec_nxt    = w_take ? r_run_max :
                        ($signed(score) > $signed(r_second)) ? score : r_second;
  assign w_margin_nxt = {w_max_nxt[SCORE_W-1], w_max_nxt} - {w_sec_nxt[SCORE_W-1], w_sec_nxt};
  assign margin       = r_margin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_second <= '0;
      r_margin <= '0;
    end else if (w_restart) begin
      r_second <= MOST_NEG;
    end else if (w_xfer) begin
      r_second <= w_sec_nxt;
      if (w_last) r_margin <= w_margin_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Randomised and directed bench for output_argmax against a array-based argmax model.
module tb_output_argmax;
  localparam int NC = 10;
  localparam int SW = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, score_valid = 1'b0, result_ready = 1'b0;
  logic [SW-1:0] score = '0;
  logic          score_ready, busy, result_valid;
  logic [3:0]    class_idx;
  logic [SW-1:0] max_score;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  logic [SW:0]   margin;
`endif

  int            n_tests = 0, n_fail = 0;
  logic [SW-1:0] sc [NC];
  int            e_idx, e_max, e_mg;

  output_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .score_valid(score_valid), .score(score),
    .score_ready(score_ready), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .class_idx(class_idx), .max_score(max_score)
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    , .margin(margin)
`endif
  );

  always #5 clk = ~clk;

  // Reference: first index of the maximum; margin = max minus the best of the other scores.
  task automatic model();
    int sec;
    e_idx = 0;
    e_max = $signed(sc[0]);
    for (int i = 1; i < NC; i++)
      if ($signed(sc[i]) > e_max) begin e_max = $signed(sc[i]); e_idx = i; end
    sec = -(1 << (SW - 1));
    for (int i = 0; i < NC; i++)
      if (i != e_idx && $signed(sc[i]) > sec) sec = $signed(sc[i]);
    e_mg = e_max - sec;
  endtask

  // Called at a negedge; start is paired with a junk beat that must be discarded.
  task automatic run_set(input bit gaps);
    start = 1'b1; score_valid = 1'b1; score = 16'h7fff;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (gaps) begin score_valid = 1'b0; score = 16'h7fff; @(negedge clk); end
      score_valid = 1'b1; score = sc[i];
      if (i == NC - 1) begin
        n_tests++;
        if (result_valid !== 1'b0) begin
          n_fail++; $display("FAIL early_valid: result_valid=%b want 0", result_valid);
        end
      end
      @(negedge clk);
    end
    score_valid = 1'b0;
  endtask

  task automatic consume();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({score_ready, busy, result_valid, class_idx, max_score} !== '0) begin
      n_fail++; $display("FAIL reset: rdy/busy/vld/idx/max=%b/%b/%b/%0d/%0d want all 0",
                         score_ready, busy, result_valid, class_idx, max_score);
    end
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    n_tests++;
    if (margin !== '0) begin n_fail++; $display("FAIL reset_margin: got %0d want 0", margin); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_spec_vectors();
    int v [NC] = '{3, -1, 7, 2, 0, 5, 7, 1, -4, 6};
    int exp_idx [3] = '{2, 0, 9};
    int exp_max [3] = '{7, -32768, 9};
    int exp_mg  [3] = '{0, 0, 1};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NC; i++)
        sc[i] = (t == 0) ? 16'(v[i]) : (t == 1) ? 16'h8000 : 16'(i);
      run_set(t == 2);
      n_tests++;
      if ({result_valid, score_ready, class_idx, max_score} !==
          {1'b1, 1'b0, 4'(exp_idx[t]), 16'(exp_max[t])}) begin
        n_fail++; $display("FAIL spec_vec%0d: vld/rdy/idx/max=%b/%b/%0d/%0d want 1/0/%0d/%0d", t,
                           result_valid, score_ready, class_idx, $signed(max_score), exp_idx[t], exp_max[t]);
      end
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      n_tests++;
      if (margin !== 17'(exp_mg[t])) begin
        n_fail++; $display("FAIL spec_margin%0d: got %0d want %0d", t, margin, exp_mg[t]);
      end
`endif
      consume();
    end
  endtask

  task automatic test_hold();
    logic [3:0] h_idx;
    logic [SW-1:0] h_max;
    for (int i = 0; i < NC; i++) sc[i] = 16'($urandom);
    model();
    run_set(1'b0);
    h_idx = class_idx; h_max = max_score;
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      n_tests++;
      if ({result_valid, busy, class_idx, max_score} !== {1'b1, 1'b1, 4'(e_idx), 16'(e_max)}) begin
        n_fail++; $display("FAIL hold_c%0d: vld/busy/idx/max=%b/%b/%0d/%0d want 1/1/%0d/%0d", c,
                           result_valid, busy, class_idx, $signed(max_score), e_idx, e_max);
      end
      @(negedge clk);
    end
    start = 1'b0;
    consume();
    n_tests++;
    if ({busy, result_valid, score_ready, class_idx, max_score} !== {3'b000, h_idx, h_max}) begin
      n_fail++; $display("FAIL hold_release: busy/vld/rdy/idx/max=%b/%b/%b/%0d/%0d want 0/0/0/%0d/%0d",
                         busy, result_valid, score_ready, class_idx, max_score, h_idx, h_max);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_no_queued_start: busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin score_valid = 1'b1; score = 16'd30000; @(negedge clk); end
    for (int i = 0; i < NC; i++) sc[i] = 16'(int'($urandom_range(0, 1099)) - 1000);
    sc[3] = 16'd100;
    model();
    run_set(1'b0);
    n_tests++;
    if ({result_valid, class_idx, max_score} !== {1'b1, 4'd3, 16'd100}) begin
      n_fail++; $display("FAIL abort: vld/idx/max=%b/%0d/%0d want 1/3/100",
                         result_valid, class_idx, $signed(max_score));
    end
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    n_tests++;
    if (margin !== 17'(e_mg)) begin n_fail++; $display("FAIL abort_margin: got %0d want %0d", margin, e_mg); end
`endif
    consume();
  endtask

  task automatic test_random();
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < NC; i++)
        sc[i] = (s % 2) ? 16'(int'($urandom_range(0, 6)) - 3) : 16'($urandom);
      model();
      run_set(1'($urandom_range(0, 1)));
      n_tests++;
      if ({result_valid, class_idx, max_score} !== {1'b1, 4'(e_idx), 16'(e_max)}) begin
        n_fail++; $display("FAIL random%0d: vld/idx/max=%b/%0d/%0d want 1/%0d/%0d", s,
                           result_valid, class_idx, $signed(max_score), e_idx, e_max);
      end
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      n_tests++;
      if (margin !== 17'(e_mg)) begin
        n_fail++; $display("FAIL random_margin%0d: got %0d want %0d", s, margin, e_mg);
      end
`endif
      consume();
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin score_valid = 1'b1; score = 16'(i); @(negedge clk); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, score_ready, result_valid, class_idx, max_score} !== '0) begin
      n_fail++; $display("FAIL async_reset: busy/rdy/vld/idx/max=%b/%b/%b/%0d/%0d want all 0",
                         busy, score_ready, result_valid, class_idx, max_score);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NC; i++) sc[i] = 16'($urandom);
    model();
    run_set(1'b0);
    n_tests++;
    if ({result_valid, class_idx, max_score} !== {1'b1, 4'(e_idx), 16'(e_max)}) begin
      n_fail++; $display("FAIL post_reset_start: vld/idx/max=%b/%0d/%0d want 1/%0d/%0d",
                         result_valid, class_idx, $signed(max_score), e_idx, e_max);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_hold();
    test_abort();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
